// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack handshake carrying one word into an asynchronous domain.
// Optional ack-wait timeout with sticky err_out is compiled in with CDC_HS_TIMEOUT_EN.
module cdc_handshake_tx #(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned SyncRegWidth  = 2,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 load_in,
  input  logic [DataWidth-1:0] data_in,
  output logic                 ready_out,
  output logic                 req_out,
  output logic [DataWidth-1:0] data_out,
  input  logic                 ack_in,
  output logic                 done_out,
  output logic                 err_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic [DataWidth-1:0]    data_q, data_d;
  logic                    done_q, done_d;
  logic                    ready_q;
  logic [SyncRegWidth-1:0] sync_q;
  logic                    ack_sync;
  logic                    timeout_hit_c;
  logic                    timeout_fire_c;
  logic                    abort_c;

  // ack_in is asynchronous; only the last synchronizer stage is used
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncRegWidth-2:0], ack_in};
    end
  end

  assign ack_sync = sync_q[SyncRegWidth-1];

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ready_q <= (state_d == IDLE);
    end
  end

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    data_d         = data_q;
    done_d         = 1'b0;
    timeout_fire_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_in) begin
          data_d  = data_in;
          req_d   = 1'b1;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = REQ_LO;
        end else if (timeout_hit_c) begin
          req_d          = 1'b0;
          state_d        = REQ_LO;
          timeout_fire_c = 1'b1;
        end
      end
      REQ_LO: begin
        // A transfer aborted in REQ_HI still drains through REQ_LO but never reports done
        if (!ack_sync) begin
          state_d = IDLE;
          done_d  = !abort_c;
        end else if (timeout_hit_c) begin
          state_d        = IDLE;
          timeout_fire_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef CDC_HS_TIMEOUT_EN
  localparam int unsigned CntWidth = 16;

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q;
  logic                abort_q, abort_d;

  always_comb begin
    cnt_d = cnt_q + CntWidth'(1);
    if ((state_q == IDLE) || (state_d != state_q)) begin
      cnt_d = '0;
    end
    abort_d = abort_q;
    if ((state_q == IDLE) && (state_d == REQ_HI)) begin
      abort_d = 1'b0;
    end else if (timeout_fire_c && (state_q == REQ_HI)) begin
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_q | timeout_fire_c;
      abort_q <= abort_d;
    end
  end

  // Fires on the edge that completes TimeoutCycles cycles in the current phase
  assign timeout_hit_c = (cnt_q == CntWidth'(TimeoutCycles - 1));
  assign abort_c       = abort_q;
  assign err_out       = err_q;
`else
  logic unused_timeout_c;

  assign timeout_hit_c    = 1'b0;
  assign abort_c          = 1'b0;
  assign err_out          = 1'b0;
  assign unused_timeout_c = timeout_fire_c ^ (^32'(TimeoutCycles));
`endif

  assign ready_out = ready_q;
  assign req_out   = req_q;
  assign data_out  = data_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: directed scenarios plus randomized transfers
// against a latency/data model with a delayed-echo far side.
module tb_cdc_handshake_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned S  = 2;
  localparam int unsigned TO = 10;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          load_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic          req_out;
  logic [DW-1:0] data_out;
  logic          ack_in;
  logic          done_out;
  logic          err_out;

  logic          far_auto;
  logic          ack_force;
  int            far_delay;
  logic [15:0]   req_hist = '0;

  int errors = 0;
  int checks = 0;

  cdc_handshake_tx #(
    .DataWidth(DW),
    .SyncRegWidth(S),
    .TimeoutCycles(TO)
  ) dut (
    .clk(clk),
    .rst_in(rst_in),
    .load_in(load_in),
    .data_in(data_in),
    .ready_out(ready_out),
    .req_out(req_out),
    .data_out(data_out),
    .ack_in(ack_in),
    .done_out(done_out),
    .err_out(err_out)
  );

  always #5 clk = ~clk;

  // Far side: ack echoes req after far_delay clock edges (0 = combinational echo)
  always @(posedge clk) req_hist <= {req_hist[14:0], req_out};
  assign ack_in = !far_auto ? ack_force
                : (far_delay == 0) ? req_out : req_hist[far_delay-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_in  = 1'b1;
    load_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
    tick();
  endtask

  // Starts a load now (accepted on the next edge) and returns just after the done edge.
  task automatic run_xfer(input logic [DW-1:0] word, input int dly, input string tag);
    int lat;
    int fall;
    bit held;
    bit busy;
    lat  = -1;
    fall = -1;
    held = 1'b1;
    busy = 1'b1;
    chk({tag, "_ready_pre"}, 32'(ready_out), 32'd1);
    far_auto  = 1'b1;
    far_delay = dly;
    load_in   = 1'b1;
    data_in   = word;
    tick();
    chk({tag, "_req_rise"}, 32'(req_out), 32'd1);
    chk({tag, "_capture"}, 32'(data_out), 32'(word));
    for (int e = 1; e <= 200 && lat < 0; e++) begin
      load_in = 1'($urandom_range(0, 1));
      data_in = DW'($urandom);
      tick();
      if (fall < 0 && req_out === 1'b0) fall = e;
      if (data_out !== word) held = 1'b0;
      if (done_out === 1'b1) lat = e;
      else if (ready_out !== 1'b0) busy = 1'b0;
    end
    load_in = 1'b0;
    chk({tag, "_req_fall_edge"}, 32'(fall), 32'(S + dly + 1));
    chk({tag, "_done_latency"}, 32'(lat), 32'(2 * (S + dly + 1)));
    chk({tag, "_data_held"}, 32'(held), 32'd1);
    chk({tag, "_busy_not_ready"}, 32'(busy), 32'd1);
    chk({tag, "_ready_at_done"}, 32'(ready_out), 32'd1);
  endtask

  initial begin
    int cnt;
    int lat;
    logic [DW-1:0] w;
    rst_in    = 1'b1;
    load_in   = 1'b0;
    data_in   = '0;
    far_auto  = 1'b1;
    far_delay = 0;
    ack_force = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_req", 32'(req_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    rst_in = 1'b0;
    tick();
    chk("post_rst_ready", 32'(ready_out), 32'd1);

    // Basic transfer, zero far delay: done six edges after load
    run_xfer(8'hA5, 0, "basic");
    tick();
    chk("basic_single_pulse", 32'(done_out), 32'd0);
    chk("basic_data_final", 32'(data_out), 32'hA5);

    // Load during REQ_HI is ignored
    load_in = 1'b1;
    data_in = 8'h11;
    tick();
    load_in = 1'b1;
    data_in = 8'h3C;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      load_in = 1'b0;
      if (done_out === 1'b1) cnt++;
    end
    chk("ignore_data", 32'(data_out), 32'h11);
    chk("ignore_done_count", 32'(cnt), 32'd1);

    // Back-to-back: second load issued on the done cycle
    run_xfer(8'h01, 0, "b2b_first");
    run_xfer(8'h02, 0, "b2b_second");
    tick();
    chk("b2b_single_pulse", 32'(done_out), 32'd0);

    // Randomized transfers with random far delay, optional chaining
    for (int n = 0; n < 16; n++) begin
      w = DW'($urandom);
      run_xfer(w, int'($urandom_range(0, 4)), "rand");
      if ($urandom_range(0, 1) == 0) begin
        cnt = int'($urandom_range(1, 3));
        for (int i = 0; i < cnt; i++) begin
          tick();
          chk("rand_idle_no_done", 32'(done_out), 32'd0);
        end
      end
    end
    chk("rand_err_clear", 32'(err_out), 32'd0);

    // Reset while in REQ_LO aborts the transfer
    tick();
    far_delay = 1;
    load_in   = 1'b1;
    data_in   = 8'h5A;
    tick();
    load_in = 1'b0;
    cnt = 0;
    while (req_out !== 1'b0 && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("rstmid_reached_lo", 32'(cnt < 50), 32'd1);
    #2 rst_in = 1'b1;
    #1;
    chk("rstmid_req", 32'(req_out), 32'd0);
    chk("rstmid_done", 32'(done_out), 32'd0);
    chk("rstmid_data", 32'(data_out), 32'd0);
    tick();
    rst_in = 1'b0;
    tick();
    chk("rstmid_ready_after", 32'(ready_out), 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_out === 1'b1) cnt++;
    end
    chk("rstmid_no_done", 32'(cnt), 32'd0);

    // Stale ack high before load: stalls in REQ_LO until ack falls
    far_auto  = 1'b0;
    ack_force = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("stale_ready", 32'(ready_out), 32'd1);
    load_in = 1'b1;
    data_in = 8'h77;
    tick();
    load_in = 1'b0;
    chk("stale_req_rise", 32'(req_out), 32'd1);
    tick();
    chk("stale_req_fall", 32'(req_out), 32'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_out === 1'b1) cnt++;
    end
    chk("stale_stall_no_done", 32'(cnt), 32'd0);
    chk("stale_stall_busy", 32'(ready_out), 32'd0);
    ack_force = 1'b0;
    lat = -1;
    for (int e = 1; e <= 50 && lat < 0; e++) begin
      tick();
      if (done_out === 1'b1) lat = e;
    end
    chk("stale_done_latency", 32'(lat), 32'(S + 1));
    chk("stale_data", 32'(data_out), 32'h77);

    // Ack never arrives
    do_reset();
    far_auto  = 1'b0;
    ack_force = 1'b0;
    load_in   = 1'b1;
    data_in   = 8'hC3;
    tick();
    load_in = 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
    for (int e = 1; e < int'(TO); e++) tick();
    chk("to_req_before", 32'(req_out), 32'd1);
    chk("to_err_before", 32'(err_out), 32'd0);
    tick();
    chk("to_req_fall", 32'(req_out), 32'd0);
    chk("to_err_set", 32'(err_out), 32'd1);
    chk("to_no_done_hi", 32'(done_out), 32'd0);
    tick();
    chk("to_idle", 32'(ready_out), 32'd1);
    chk("to_no_done_lo", 32'(done_out), 32'd0);
    tick();
    run_xfer(8'h5C, 0, "to_after");
    chk("to_err_sticky", 32'(err_out), 32'd1);
    chk("to_after_data", 32'(data_out), 32'h5C);
`else
    cnt = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (done_out === 1'b1) cnt++;
    end
    chk("wait_req_held", 32'(req_out), 32'd1);
    chk("wait_err_zero", 32'(err_out), 32'd0);
    chk("wait_busy", 32'(ready_out), 32'd0);
    chk("wait_no_done", 32'(cnt), 32'd0);
    do_reset();
    far_auto = 1'b1;
    run_xfer(8'h5C, 0, "wait_after");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 Parameter DataWidth, default 8, width of the transferred word.
REQ-002 Parameter SyncRegWidth, default 2, flop depth of the ack synchronizer; legal values 2 and 3.
REQ-003 Parameter TimeoutCycles, default 255, ack wait limit per phase; legal 1..65535.
REQ-004 clk  input  1  single source-domain clock; all state on posedge.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 load_in  input  1  request to send data_in; sampled only when ready_out=1.
REQ-007 data_in  input  DataWidth  word to transfer.
REQ-008 ready_out  output  1  high when idle and able to accept load_in.
REQ-009 req_out  output  1  four-phase request level to the far domain.
REQ-010 data_out  output  DataWidth  captured word, held stable from capture until the next accepted load.
REQ-011 ack_in  input  1  four-phase acknowledge level from the far domain, asynchronous to clk.
REQ-012 done_out  output  1  one-cycle pulse on completed handshake.
REQ-013 err_out  output  1  sticky timeout flag.

Function
REQ-014 ack_in SHALL pass through a SyncRegWidth-deep shift chain (reset 0) before use; ack_sync is the chain's last stage.
REQ-015 FSM states SHALL be IDLE, REQ_HI, REQ_LO; ready_out SHALL equal (state==IDLE), registered.
REQ-016 IDLE with load_in=1: SHALL capture data_in into data_out, set req_out=1 and enter REQ_HI on the same edge.
REQ-017 load_in SHALL be ignored in REQ_HI and REQ_LO; data_out SHALL not change.
REQ-018 REQ_HI with ack_sync=1: SHALL clear req_out and enter REQ_LO on that edge.
REQ-019 REQ_LO with ack_sync=0: SHALL enter IDLE and pulse done_out for exactly one cycle on that edge.
REQ-020 Minimum load-to-done latency SHALL be 2*SyncRegWidth+2 cycles with zero far-side delay; no cycle SHALL be added beyond the sync depth.
REQ-021 Load asserted in the cycle where done_out=1 (ready_out=1) SHALL be accepted; back-to-back transfers need no idle cycle.
REQ-022 ack_sync high while in IDLE (stale ack) SHALL be ignored; the next accepted load SHALL still enter REQ_HI and wait for ack_sync to be sampled 1.
REQ-023 req_out SHALL change only on clk edges and SHALL be driven directly from a flop (glitch-free into the far domain).

Reset
REQ-024 rst_in=1 SHALL asynchronously force state=IDLE, req_out=0, data_out=0, done_out=0, err_out=0, sync chain=0, timeout counter=0.
REQ-025 Reset mid-handshake SHALL abort the transfer with no done_out pulse; ready_out SHALL be 1 on the first edge after rst_in deasserts.

Configuration
REQ-026 Macro CDC_HS_TIMEOUT_EN SHALL compile in a 16-bit wait counter, cleared on every entry to REQ_HI or REQ_LO and incremented each cycle in those states.
REQ-027 With CDC_HS_TIMEOUT_EN: counter reaching TimeoutCycles in REQ_HI SHALL set err_out, clear req_out and enter REQ_LO; in REQ_LO it SHALL set err_out and enter IDLE; no done_out on timeout.
REQ-028 With CDC_HS_TIMEOUT_EN: err_out SHALL stay set until rst_in; further transfers SHALL proceed normally.
REQ-029 Without CDC_HS_TIMEOUT_EN: no counter SHALL exist, err_out SHALL be tied 0, and REQ_HI/REQ_LO SHALL wait indefinitely.

Verification
REQ-030 Reset, load_in=1 data_in=8'hA5, far model echoes req->ack after 0 cycles, SyncRegWidth=2 -> data_out=A5, req_out 1 then 0, done_out pulse at cycle 6, ready_out=1.
REQ-031 Load 8'h3C during REQ_HI of an 8'h11 transfer -> data_out stays 11, only one done_out pulse.
REQ-032 Two loads (8'h01, 8'h02), second held on the done_out cycle -> both accepted, two done_out pulses, no idle gap.
REQ-033 rst_in pulsed while in REQ_LO -> req_out=0, no done_out, ready_out=1 one edge after release.
REQ-034 CDC_HS_TIMEOUT_EN, TimeoutCycles=10, ack_in held 0 -> req_out falls and err_out=1 at 10 cycles after req rise, state IDLE next edge, no done_out; following normal transfer completes with err_out still 1.
REQ-035 ack_in held 1 before load (stale) -> handshake stalls in REQ_LO until ack_in falls, then done_out pulses.
